// File: rtl/mlkem_arbiter.sv
// Two-requester ownership arbiter for a shared ML-KEM core, with a flush gap driven between owners.
// Define MLKEM_ARB_WDOG_EN to build in the ownership watchdog (TIMEOUT); otherwise abort0/abort1 are tied low.
module mlkem_arbiter #(
   parameter int unsigned GAP_CYCLES = 2,
   parameter logic [7:0]  RESET_CMD  = 8'h01,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        abort0,
   output logic        abort1,
   input  logic [7:0]  control0,
   input  logic [7:0]  control1,
   input  logic [63:0] data_in0,
   input  logic [63:0] data_in1,
   input  logic [15:0] add0,
   input  logic [15:0] add1,
   output logic [63:0] data_out0,
   output logic [63:0] data_out1,
   output logic [1:0]  end_op0,
   output logic [1:0]  end_op1,
   output logic [7:0]  control_m,
   output logic [63:0] data_in_m,
   output logic [15:0] add_m,
   input  logic [63:0] data_out_m,
   input  logic [1:0]  end_op_m,
   output logic [1:0]  owner
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] OWN0  = 2'b01;
   localparam logic [1:0] OWN1  = 2'b10;
   localparam logic [1:0] FLUSH = 2'b11;

   // Loaded on FLUSH entry; FLUSH lasts until the counter has reached zero, i.e. GAP_CYCLES cycles.
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   logic [1:0] state_r;
   logic [1:0] state_s;
   logic       rr_r;
   logic       rr_s;
   logic [3:0] flush_cnt_r;
   logic [3:0] flush_cnt_s;
   logic       wd_expire_s;

`ifdef MLKEM_ARB_WDOG_EN
   logic [15:0] wd_cnt_r;
   logic [15:0] wd_cnt_s;
   logic [7:0]  ctl_prev_r;
   logic [7:0]  ctl_next_s;
   logic [7:0]  own_ctl_s;
   logic        own_req_s;
   logic        abort0_r;
   logic        abort1_r;

   // Watchdog next-count and expiry; any change of the owner's command word restarts the count.
   always_comb begin
      own_ctl_s   = 8'h00;
      own_req_s   = 1'b0;
      wd_cnt_s    = 16'h0000;
      wd_expire_s = 1'b0;
      ctl_next_s  = control0;
      case (state_r)
         OWN0: begin
            own_ctl_s = control0;
            own_req_s = req0;
         end
         OWN1: begin
            own_ctl_s = control1;
            own_req_s = req1;
         end
         default: begin
            own_ctl_s = 8'h00;
            own_req_s = 1'b0;
         end
      endcase
      if ((state_r == OWN0) || (state_r == OWN1)) begin
         if (own_ctl_s != ctl_prev_r) begin
            wd_cnt_s = 16'h0000;
         end else begin
            wd_cnt_s = wd_cnt_r + 16'h0001;
         end
         wd_expire_s = own_req_s && (own_ctl_s == ctl_prev_r) && ((wd_cnt_r + 16'h0001) == TIMEOUT);
      end else begin
         wd_cnt_s    = 16'h0000;
         wd_expire_s = 1'b0;
      end
      if (state_s == OWN1) begin
         ctl_next_s = control1;
      end else begin
         ctl_next_s = control0;
      end
   end

   // Watchdog counter, command-word history and one-cycle abort pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_cnt_r   <= 16'h0000;
         ctl_prev_r <= 8'h00;
         abort0_r   <= 1'b0;
         abort1_r   <= 1'b0;
      end else begin
         wd_cnt_r   <= wd_cnt_s;
         ctl_prev_r <= ctl_next_s;
         abort0_r   <= wd_expire_s && (state_r == OWN0);
         abort1_r   <= wd_expire_s && (state_r == OWN1);
      end
   end

   assign abort0 = abort0_r;
   assign abort1 = abort1_r;
`else
   assign wd_expire_s = 1'b0;
   assign abort0      = 1'b0;
   assign abort1      = 1'b0;

   // TIMEOUT is only meaningful with the watchdog built in.
   if (TIMEOUT == 16'h0000) begin : g_timeout_unused
   end
`endif

   // Ownership FSM: arbitration only in IDLE, round-robin on contention, fixed flush gap on release.
   always_comb begin
      state_s     = state_r;
      rr_s        = rr_r;
      flush_cnt_s = flush_cnt_r;
      case (state_r)
         IDLE: begin
            if (req0 && (!req1 || !rr_r)) begin
               state_s = OWN0;
               rr_s    = 1'b1;
            end else if (req1) begin
               state_s = OWN1;
               rr_s    = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         OWN0: begin
            if (!req0 || wd_expire_s) begin
               state_s     = FLUSH;
               flush_cnt_s = GAP_LOAD;
            end else begin
               state_s = OWN0;
            end
         end
         OWN1: begin
            if (!req1 || wd_expire_s) begin
               state_s     = FLUSH;
               flush_cnt_s = GAP_LOAD;
            end else begin
               state_s = OWN1;
            end
         end
         FLUSH: begin
            if (flush_cnt_r == 4'h0) begin
               state_s = IDLE;
            end else begin
               flush_cnt_s = flush_cnt_r - 4'h1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, round-robin pointer and flush counter; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         rr_r        <= 1'b0;
         flush_cnt_r <= 4'h0;
      end else begin
         state_r     <= state_s;
         rr_r        <= rr_s;
         flush_cnt_r <= flush_cnt_s;
      end
   end

   // Core-side and requester-side steering; the non-owner always sees zeros.
   always_comb begin
      control_m = 8'h00;
      data_in_m = 64'h0;
      add_m     = 16'h0000;
      data_out0 = 64'h0;
      data_out1 = 64'h0;
      end_op0   = 2'b00;
      end_op1   = 2'b00;
      case (state_r)
         OWN0: begin
            control_m = control0;
            data_in_m = data_in0;
            add_m     = add0;
            data_out0 = data_out_m;
            end_op0   = end_op_m;
         end
         OWN1: begin
            control_m = control1;
            data_in_m = data_in1;
            add_m     = add1;
            data_out1 = data_out_m;
            end_op1   = end_op_m;
         end
         FLUSH: begin
            control_m = RESET_CMD;
         end
         default: begin
            control_m = 8'h00;
         end
      endcase
   end

   assign gnt0  = (state_r == OWN0);
   assign gnt1  = (state_r == OWN1);
   assign owner = {gnt1, gnt0};

endmodule
